step_tracker: RTL and testbench

Downstream consumer of the pedometer classifier's single-bit `step` decision. It qualifies that decision per accelerometer sample, debounces it, and applies a refractory window so one physical stride is counted once. It keeps a saturating step count and reports the sample interval between consecutive counted steps (cadence). Its outputs feed the system-level readout.

---
 rtl/step_tracker.sv | 103 ++++++++++
 tb/tb_step_tracker.sv | 114 +++++++++++
 2 files changed

// File: rtl/step_tracker.sv
// step_tracker: debounces the classifier step decision, applies a refractory window, counts steps and measures cadence
module step_tracker #(
  parameter int CNT_W    = 16,
  parameter int INT_W    = 12,
  parameter int DEBOUNCE = 2,
  parameter int REFRACT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             step,
  input  logic             clear,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_count,
  output logic [INT_W-1:0] step_interval,
  output logic             interval_valid
);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);
  localparam logic [7:0] RFR = 8'(REFRACT);
  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_REFR, S_WAIT} state_t;
  state_t           state_q, state_d;
  logic [3:0]       deb_q, deb_d;
  logic [7:0]       ref_q, ref_d;
  logic [INT_W-1:0] gap_q, gap_d, gap_inc, interval_q, interval_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d, iv_q, iv_d, seen_q, seen_d, cnt_evt;
  assign gap_inc = &gap_q ? gap_q : gap_q + 1'b1;
  // Qualification FSM: decides count events and the next debounce/refractory state
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    ref_d   = ref_q;
    cnt_evt = 1'b0;
    if (sample_valid) begin
      case (state_q)
        S_IDLE:
          if (step) begin
            deb_d = 4'd1;
            if (DEB == 4'd1) cnt_evt = 1'b1;
            else state_d = S_CONFIRM;
          end
        S_CONFIRM:
          if (step) begin
            deb_d = deb_q + 4'd1;
            if (deb_q + 4'd1 == DEB) cnt_evt = 1'b1;
          end else begin
            deb_d   = 4'd0;
            state_d = S_IDLE;
          end
        S_REFR: begin
          ref_d = ref_q + 8'd1;
          if (ref_q + 8'd1 == RFR) begin
            ref_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
        default: state_d = step ? S_WAIT : S_IDLE;
      endcase
      if (cnt_evt) begin
        deb_d   = 4'd0;
        ref_d   = 8'd0;
        state_d = (RFR == 8'd0) ? S_WAIT : S_REFR;
      end
    end
  end
  // Counter, cadence and output next-state values driven by count events
  always_comb begin
    pulse_d    = cnt_evt;
    count_d    = cnt_evt && !(&count_q) ? count_q + 1'b1 : count_q;
    gap_d      = !sample_valid ? gap_q : cnt_evt ? '0 : gap_inc;
    interval_d = cnt_evt && seen_q ? gap_inc : interval_q;
    iv_d       = iv_q | (cnt_evt & seen_q);
    seen_d     = seen_q | cnt_evt;
  end
  // State register; clear acts exactly like reset on this block
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= S_IDLE;
      deb_q      <= '0;
      ref_q      <= '0;
      gap_q      <= '0;
      count_q    <= '0;
      interval_q <= '0;
      pulse_q    <= 1'b0;
      iv_q       <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_q      <= deb_d;
      ref_q      <= ref_d;
      gap_q      <= gap_d;
      count_q    <= count_d;
      interval_q <= interval_d;
      pulse_q    <= pulse_d;
      iv_q       <= iv_d;
      seen_q     <= seen_d;
    end
  end
  assign step_pulse     = pulse_q;
  assign step_count     = count_q;
  assign step_interval  = interval_q;
  assign interval_valid = iv_q;
endmodule

// File: tb/tb_step_tracker.sv
// tb_step_tracker: directed self-checking bench with an expected-pulse scoreboard
module tb_step_tracker;
  logic       clk = 1'b0;
  logic       rst, sample_valid, step, clear;
  logic       step_pulse, interval_valid;
  logic [3:0] step_count, step_interval;
  int         total = 0, bad = 0, npulse = 0, n0;
  logic       exp_q[$];
  step_tracker #(.CNT_W(4), .INT_W(4), .DEBOUNCE(2), .REFRACT(8)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .step(step), .clear(clear),
    .step_pulse(step_pulse), .step_count(step_count), .step_interval(step_interval),
    .interval_valid(interval_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic smp(input logic v, input logic s, input logic c, input logic ep);
    logic e;
    sample_valid = v;
    step = s;
    clear = c;
    exp_q.push_back(ep);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pulse", {31'd0, step_pulse}, {31'd0, e});
    if (step_pulse) npulse++;
  endtask
  task automatic outs(input string tag, input int cnt, input int itv, input logic iv);
    chk({tag, "_count"}, {28'd0, step_count}, cnt);
    chk({tag, "_interval"}, {28'd0, step_interval}, itv);
    chk({tag, "_ivalid"}, {31'd0, interval_valid}, {31'd0, iv});
  endtask
  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    step = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulse", {31'd0, step_pulse}, 0);
    outs("reset", 0, 0, 1'b0);
    rst = 1'b0;
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    outs("basic", 1, 0, 1'b0);
    repeat (9) smp(1, 0, 0, 0);
    smp(1, 0, 1, 0);
    outs("clr1", 0, 0, 1'b0);
    repeat (10) begin
      smp(1, 1, 0, 0);
      smp(1, 0, 0, 0);
    end
    outs("glitch", 0, 0, 1'b0);
    smp(1, 0, 1, 0);
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    repeat (9) smp(1, 0, 0, 0);
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    outs("interval", 2, 11, 1'b1);
    repeat (9) smp(1, 0, 0, 0);
    n0 = npulse;
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    repeat (38) smp(1, 1, 0, 0);
    chk("held_pulses", npulse - n0, 1);
    outs("held", 3, 11, 1'b1);
    smp(1, 0, 0, 0);
    repeat (30) smp(1, 0, 0, 0);
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    outs("int_sat", 4, 15, 1'b1);
    smp(1, 0, 1, 0);
    repeat (20) smp(0, 1, 0, 0);
    outs("gated", 0, 0, 1'b0);
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    outs("gated_cnt", 1, 0, 1'b0);
    smp(1, 0, 1, 0);
    n0 = npulse;
    for (int i = 0; i < 17; i++) begin
      smp(1, 1, 0, 0);
      smp(1, 1, 0, 1);
      smp(0, 0, 0, 0);
      smp(0, 1, 0, 0);
      repeat (9) smp(1, 0, 0, 0);
    end
    chk("sat_pulses", npulse - n0, 17);
    outs("sat", 15, 11, 1'b1);
    smp(1, 1, 0, 0);
    smp(1, 1, 1, 0);
    outs("clr_confirm", 0, 0, 1'b0);
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    outs("after_clr", 1, 0, 1'b0);
    smp(1, 0, 0, 0);
    smp(1, 0, 0, 0);
    rst = 1'b1;
    smp(1, 1, 0, 0);
    rst = 1'b0;
    outs("rst_refr", 0, 0, 1'b0);
    smp(1, 1, 0, 0);
    smp(1, 1, 0, 1);
    outs("after_rst", 1, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
